// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op/state encodings and width default for the HI/LO unit
package hilo_pkg;

  // Default width of each half (HI, LO); the accumulator is twice this.
  localparam int HILO_DATA_W = 32;

  // Operation encodings on the op port; 3'b11x is reserved and acts as NOP.
  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_WR_BOTH = 3'b001;
  localparam logic [2:0] OP_WR_HI   = 3'b010;
  localparam logic [2:0] OP_WR_LO   = 3'b011;
  localparam logic [2:0] OP_MADD    = 3'b100;
  localparam logic [2:0] OP_MSUB    = 3'b101;

  // Controller states: IDLE accepts ops, ACC performs the pending accumulate.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // True for the two ops that start a two-cycle accumulate.
  function automatic logic is_acc_op(input logic [2:0] op);
    return (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_addsub.sv
// rtl/hilo_addsub.sv - combinational 2*DATA_W add/subtract for the accumulate path
module hilo_addsub #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] acc,
  input  logic [2*DATA_W-1:0] prod,
  input  logic                sub,
  output logic [2*DATA_W-1:0] res
);

  // Modulo 2^(2*DATA_W): carry/borrow out is simply dropped.
  assign res = sub ? (acc - prod) : (acc + prod);

endmodule

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register pair with MADD/MSUB accumulate; optional HILO_BYPASS_EN forwarding
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int DATA_W = HILO_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [2:0]          op,
  input  logic [DATA_W-1:0]   hi_i,
  input  logic [DATA_W-1:0]   lo_i,
  input  logic [2*DATA_W-1:0] prod_i,
  input  logic                flush,
  output logic                stall_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o
);

  state_t              state;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic [2*DATA_W-1:0] prod_q;
  logic                sub_q;
  logic [2*DATA_W-1:0] acc_res;
  logic                accept;

  // An op is only taken in IDLE and only when the pipeline is not flushing.
  assign accept = (state == ST_IDLE) && op_valid && !flush;

  hilo_addsub #(
    .DATA_W(DATA_W)
  ) u_addsub (
    .acc  ({hi_q, lo_q}),
    .prod (prod_q),
    .sub  (sub_q),
    .res  (acc_res)
  );

  // Control FSM and HI/LO/product registers; reset overrides any in-flight accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      prod_q <= '0;
      sub_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_WR_BOTH: begin
                hi_q <= hi_i;
                lo_q <= lo_i;
              end
              OP_WR_HI: hi_q <= hi_i;
              OP_WR_LO: lo_q <= lo_i;
              OP_MADD, OP_MSUB: begin
                prod_q <= prod_i;
                sub_q  <= (op == OP_MSUB);
                state  <= ST_ACC;
              end
              default: ;
            endcase
          end
        end
        ST_ACC: begin
          // A flush here abandons the accumulate and leaves HI/LO as they were.
          if (!flush) begin
            {hi_q, lo_q} <= acc_res;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Upstream must hold its op for the single accumulate cycle.
  assign stall_o = (state == ST_ACC);

`ifdef HILO_BYPASS_EN
  // Forward the value that the next edge will write, per half, so readers see it this cycle.
  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (rst) begin
      hi_o = '0;
      lo_o = '0;
    end else if (state == ST_ACC) begin
      if (!flush) begin
        {hi_o, lo_o} = acc_res;
      end
    end else if (accept && !is_acc_op(op)) begin
      case (op)
        OP_WR_BOTH: begin
          hi_o = hi_i;
          lo_o = lo_i;
        end
        OP_WR_HI: hi_o = hi_i;
        OP_WR_LO: lo_o = lo_i;
        default: ;
      endcase
    end
  end
`else
  // Registered outputs only: no combinational path from inputs to hi_o/lo_o.
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - self-checking bench for hilo_unit with a 64-bit behavioural model
module tb_hilo_unit;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic [63:0] prod_i;
  logic        flush;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_cmp = 0;
  int n_bad = 0;

  hilo_unit #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .hi_i     (hi_i),
    .lo_i     (lo_i),
    .prod_i   (prod_i),
    .flush    (flush),
    .stall_o  (stall_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Behavioural model: the 64-bit HI:LO value plus one pending accumulate.
  logic [63:0] m_hilo;
  logic        m_pend;
  logic [63:0] m_prod;
  logic        m_sub;
  logic        m_ready = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_hilo = 64'd0;
      m_pend = 1'b0;
      m_prod = 64'd0;
      m_sub  = 1'b0;
      m_ready = 1'b1;
    end else if (m_pend) begin
      if (!flush) m_hilo = m_sub ? m_hilo - m_prod : m_hilo + m_prod;
      m_pend = 1'b0;
    end else if (op_valid && !flush) begin
      if (op == 3'd1) m_hilo = {hi_i, lo_i};
      else if (op == 3'd2) m_hilo[63:32] = hi_i;
      else if (op == 3'd3) m_hilo[31:0] = lo_i;
      else if (op == 3'd4 || op == 3'd5) begin
        m_pend = 1'b1;
        m_prod = prod_i;
        m_sub  = (op == 3'd5);
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    logic [63:0] e;
    if (m_ready) begin
      e = m_hilo;
`ifdef HILO_BYPASS_EN
      if (rst) e = 64'd0;
      else if (m_pend) begin
        if (!flush) e = m_sub ? m_hilo - m_prod : m_hilo + m_prod;
      end else if (op_valid && !flush) begin
        if (op == 3'd1) e = {hi_i, lo_i};
        else if (op == 3'd2) e[63:32] = hi_i;
        else if (op == 3'd3) e[31:0] = lo_i;
      end
`endif
      chk("model_hi", {32'd0, hi_o}, {32'd0, e[63:32]});
      chk("model_lo", {32'd0, lo_o}, {32'd0, e[31:0]});
      chk("model_stall", {63'd0, stall_o}, {63'd0, m_pend});
    end
  end

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] h,
                       input logic [31:0] l, input logic [63:0] p, input logic f);
    op_valid = v;
    op       = o;
    hi_i     = h;
    lo_i     = l;
    prod_i   = p;
    flush    = f;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 64'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hl(input string name, input logic [31:0] h, input logic [31:0] l,
                        input logic s);
    #1;
    chk({name, "_hi"}, {32'd0, hi_o}, {32'd0, h});
    chk({name, "_lo"}, {32'd0, lo_o}, {32'd0, l});
    chk({name, "_stall"}, {63'd0, stall_o}, {63'd0, s});
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick(); tick();
    chk_hl("reset0", 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    // Random writes, then reset for two cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd1, $urandom, $urandom, 64'd0, 1'b0);
      tick();
    end
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_hl("reset_after_wr", 32'h0, 32'h0, 1'b0);

    // Reset arriving while an accumulate is pending.
    drive(1'b1, 3'd1, 32'h5, 32'h5, 64'd0, 1'b0); tick();
    drive(1'b1, 3'd4, 32'h0, 32'h0, 64'h77, 1'b0); tick();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_hl("reset_in_acc", 32'h0, 32'h0, 1'b0);

    // Single-cycle writes.
    drive(1'b1, 3'd1, 32'h12345678, 32'h9ABCDEF0, 64'd0, 1'b0); tick(); idle();
    chk_hl("wr_both", 32'h12345678, 32'h9ABCDEF0, 1'b0);
    drive(1'b1, 3'd2, 32'hFFFFFFFF, 32'h0BAD0BAD, 64'd0, 1'b0); tick(); idle();
    chk_hl("wr_hi", 32'hFFFFFFFF, 32'h9ABCDEF0, 1'b0);
    drive(1'b1, 3'd3, 32'h0BAD0BAD, 32'h00000001, 64'd0, 1'b0); tick(); idle();
    chk_hl("wr_lo", 32'hFFFFFFFF, 32'h00000001, 1'b0);
    // Back-to-back writes with no idle in between.
    drive(1'b1, 3'd1, 32'h11111111, 32'h22222222, 64'd0, 1'b0); tick();
    drive(1'b1, 3'd2, 32'h33333333, 32'h0, 64'd0, 1'b0); tick();
    drive(1'b1, 3'd3, 32'h0, 32'h44444444, 64'd0, 1'b0); tick(); idle();
    chk_hl("wr_b2b", 32'h33333333, 32'h44444444, 1'b0);

    // MADD with carry from LO into HI.
    drive(1'b1, 3'd1, 32'h0, 32'hFFFFFFFF, 64'd0, 1'b0); tick();
    drive(1'b1, 3'd4, 32'h0, 32'h0, 64'd1, 1'b0); tick(); idle();
    #1 chk("madd_stall_hi", {63'd0, stall_o}, 64'd1);
    tick();
    chk_hl("madd_carry", 32'h1, 32'h0, 1'b0);

    // MSUB wrap-around, with a WR_BOTH held across the stall.
    drive(1'b1, 3'd1, 32'h0, 32'h0, 64'd0, 1'b0); tick();
    drive(1'b1, 3'd5, 32'h0, 32'h0, 64'd1, 1'b0); tick();
    drive(1'b1, 3'd1, 32'hAAAA0000, 32'h0000BBBB, 64'd0, 1'b0);
    #1 chk("msub_stall_hi", {63'd0, stall_o}, 64'd1);
    tick();
`ifdef HILO_BYPASS_EN
    chk_hl("msub_wrap_held", 32'hAAAA0000, 32'h0000BBBB, 1'b0);
`else
    chk_hl("msub_wrap_held", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
`endif
    tick(); idle();
    chk_hl("held_wr_accepted", 32'hAAAA0000, 32'h0000BBBB, 1'b0);

    // Flush during ACC aborts the accumulate.
    drive(1'b1, 3'd1, 32'h5, 32'h7, 64'd0, 1'b0); tick();
    drive(1'b1, 3'd4, 32'h0, 32'h0, 64'h0000000100000000, 1'b0); tick();
    drive(1'b0, 3'd0, 32'h0, 32'h0, 64'd0, 1'b1); tick(); idle();
    chk_hl("flush_acc", 32'h5, 32'h7, 1'b0);

    // Flush in IDLE drops the presented write.
    drive(1'b1, 3'd1, 32'h9, 32'h9, 64'd0, 1'b1); tick(); idle();
    chk_hl("flush_idle", 32'h5, 32'h7, 1'b0);

    // Reserved ops behave as NOP.
    drive(1'b1, 3'd6, 32'hDEAD, 32'hBEEF, 64'd9, 1'b0); tick();
    drive(1'b1, 3'd7, 32'hDEAD, 32'hBEEF, 64'd9, 1'b0); tick(); idle();
    chk_hl("reserved_nop", 32'h5, 32'h7, 1'b0);

    // WR_LO read-after-write: same cycle with bypass, next cycle without.
    drive(1'b1, 3'd3, 32'h0, 32'hA5A5A5A5, 64'd0, 1'b0);
`ifdef HILO_BYPASS_EN
    chk_hl("wr_lo_same_cycle", 32'h5, 32'hA5A5A5A5, 1'b0);
`else
    chk_hl("wr_lo_same_cycle", 32'h5, 32'h7, 1'b0);
`endif
    tick(); idle();
    chk_hl("wr_lo_next_cycle", 32'h5, 32'hA5A5A5A5, 1'b0);

    // Back-to-back MADD held by upstream: one result every two cycles.
    drive(1'b1, 3'd4, 32'h0, 32'h0, 64'd3, 1'b0);
    tick(); tick(); tick(); idle(); tick();
    chk_hl("madd_b2b", 32'h5, 32'hA5A5A5AB, 1'b0);

    // MSUB of a 64-bit product borrowing across halves.
    drive(1'b1, 3'd5, 32'h0, 32'h0, 64'h00000001_A5A5A5AC, 1'b0); tick(); idle(); tick();
    chk_hl("msub_borrow", 32'h3, 32'hFFFFFFFF, 1'b0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Parametrised successor to the HI/LO register pair in the MIPS-style core.
- Holds HI/LO and accepts single-cycle writes: WR_BOTH for mult/div results, WR_HI/WR_LO for MTHI/MTLO.
- Adds a two-cycle multiply-accumulate/subtract path (MADD/MSUB) with a pipeline stall output and a flush input.
- Sits between EX/MEM write-back of the multiplier/divider and the EX-stage readers (MFHI/MFLO).

Parameters:
- DATA_W, 32, width of HI and of LO; accumulator width is 2*DATA_W.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  operation request this cycle
- op  in  3  000 NOP, 001 WR_BOTH, 010 WR_HI, 011 WR_LO, 100 MADD, 101 MSUB, 11x reserved (treated as NOP)
- hi_i  in  DATA_W  write data for HI (WR_BOTH, WR_HI)
- lo_i  in  DATA_W  write data for LO (WR_BOTH, WR_LO)
- prod_i  in  2*DATA_W  product for MADD/MSUB; signedness already resolved upstream
- flush  in  1  pipeline flush; cancels an in-flight accumulate
- stall_o  out  1  high while the accumulate is pending; upstream must hold its op
- hi_o  out  DATA_W  current HI
- lo_o  out  DATA_W  current LO

Behaviour:
- States: IDLE, ACC. Registers: hi_q, lo_q, prod_q (2*DATA_W), sub_q (1).
- Reset (rst=1 at a clock edge): hi_q=0, lo_q=0, prod_q=0, sub_q=0, state=IDLE. This wins over everything, including reset during ACC. Outputs after reset: hi_o=0, lo_o=0, stall_o=0.
- IDLE, op_valid=1, flush=0:
  - WR_BOTH: hi_q<=hi_i, lo_q<=lo_i.
  - WR_HI: only hi_q<=hi_i; LO is untouched.
  - WR_LO: only lo_q<=lo_i; HI is untouched.
  - MADD/MSUB: prod_q<=prod_i, sub_q<=(op==MSUB), state<=ACC. HI/LO are unchanged this edge.
  - NOP/reserved: no change.
- ACC, flush=0:
  - {hi_q,lo_q} <= {hi_q,lo_q} + prod_q for MADD, or − prod_q for MSUB.
  - Arithmetic is modulo 2^(2*DATA_W); carry/borrow out is discarded and no overflow is flagged.
  - state<=IDLE.
- stall_o = (state==ACC), combinational from state. Exactly one stall cycle per MADD/MSUB.
- op_valid in ACC is ignored; no op is accepted or queued. Upstream re-presents the op after the stall.
- flush=1 in IDLE: the presented op is dropped; no state change.
- flush=1 in ACC: the accumulate is aborted, HI/LO keep their pre-MADD values, state<=IDLE.
- Latency: a write is visible on hi_o/lo_o the cycle after acceptance. A MADD/MSUB result is visible two cycles after acceptance.
- Back-to-back MADD: the second is accepted in the cycle after the ACC cycle, giving one result every 2 cycles.
- hi_o=hi_q and lo_o=lo_q (registered) unless the optional feature is enabled.

Optional Feature:
- Macro: HILO_BYPASS_EN.
- Defined: hi_o/lo_o are forwarded combinationally with the value that will be written at the next edge.
  - Applies to an accepted WR_* in IDLE, and to the accumulate result in ACC when flush=0.
  - Forwarding is per half: WR_HI forwards HI only, WR_LO forwards LO only.
  - Forced to 0 while rst=1.
  - Removes the MFHI/MFLO read-after-write hazard.
- Undefined: outputs are the registered hi_q/lo_q only. No combinational path exists from inputs to hi_o/lo_o.

Decomposition:
- Package hilo_pkg holds:
  - the op encodings (OP_NOP, OP_WR_BOTH, OP_WR_HI, OP_WR_LO, OP_MADD, OP_MSUB);
  - the state encoding (ST_IDLE, ST_ACC);
  - the DATA_W default.
- One sub-module is natural: hilo_addsub. It is a purely combinational 2*DATA_W add/subtract of {hi_q,lo_q} and prod_q selected by sub_q. It is shared by the register update and the bypass path.

Test Plan:
- Reset: rst=1 for 2 cycles after random writes -> hi_o=0, lo_o=0, stall_o=0. Repeat with rst asserted during ACC -> same, state IDLE.
- WR_BOTH hi_i=0x12345678, lo_i=0x9ABCDEF0, then WR_HI 0xFFFFFFFF, then WR_LO 0x1 -> next cycles read 12345678/9ABCDEF0, then FFFFFFFF/9ABCDEF0, then FFFFFFFF/00000001.
- HI/LO=0/0xFFFFFFFF, MADD prod_i=1 -> stall_o=1 for exactly 1 cycle; then HI=0x1, LO=0x0 (carry across halves).
- HI/LO=0/0, MSUB prod_i=1 -> HI=LO=0xFFFFFFFF (wrap-around). A WR_BOTH held during the stall is accepted only after stall_o falls.
- HI/LO=5/7, MADD prod_i=0x100000000, flush=1 in the ACC cycle -> HI=5, LO=7, stall_o=0 next cycle. Separately, flush=1 together with WR_BOTH in IDLE -> no change.
- With HILO_BYPASS_EN: WR_LO lo_i=0xA5A5A5A5 -> lo_o=0xA5A5A5A5 in the same cycle with hi_o unchanged. Without the macro -> lo_o updates one cycle later.
